// File: rtl/axi_wdma_ng_if.sv
// Bundles command, status, AXI write-master and input-stream signals of the write DMA.
// master is the DMA side, slave is the environment side.
interface axi_wdma_ng_if #(
   parameter int ADDRESS_BITS = 32,
   parameter int LENGTH_BITS  = 32,
   parameter int DATA_WIDTH   = 32
);
   localparam int BPB = DATA_WIDTH / 8;

   logic [ADDRESS_BITS-1:0] cmd_address;
   logic [LENGTH_BITS-1:0]  cmd_bytes;
   logic                    cmd_valid;
   logic                    cmd_ready;

   logic [LENGTH_BITS-1:0]  sts_bytes;
   logic                    sts_error;
   logic                    sts_early;
   logic                    sts_valid;
   logic                    sts_ready;

   logic [3:0]              axi_m_awid;
   logic [ADDRESS_BITS-1:0] axi_m_awaddr;
   logic [7:0]              axi_m_awlen;
   logic [2:0]              axi_m_awsize;
   logic [1:0]              axi_m_awburst;
   logic                    axi_m_awvalid;
   logic                    axi_m_awready;

   logic [3:0]              axi_m_wid;
   logic [DATA_WIDTH-1:0]   axi_m_wdata;
   logic [BPB-1:0]          axi_m_wstrb;
   logic                    axi_m_wlast;
   logic                    axi_m_wvalid;
   logic                    axi_m_wready;

   logic [3:0]              axi_m_bid;
   logic [1:0]              axi_m_bresp;
   logic                    axi_m_bvalid;
   logic                    axi_m_bready;

   logic [DATA_WIDTH-1:0]   din_tdata;
   logic [BPB-1:0]          din_tkeep;
   logic                    din_tlast;
   logic                    din_tvalid;
   logic                    din_tready;

   modport master (
      input  cmd_address, cmd_bytes, cmd_valid,
      output cmd_ready,
      output sts_bytes, sts_error, sts_early, sts_valid,
      input  sts_ready,
      output axi_m_awid, axi_m_awaddr, axi_m_awlen, axi_m_awsize, axi_m_awburst, axi_m_awvalid,
      input  axi_m_awready,
      output axi_m_wid, axi_m_wdata, axi_m_wstrb, axi_m_wlast, axi_m_wvalid,
      input  axi_m_wready,
      input  axi_m_bid, axi_m_bresp, axi_m_bvalid,
      output axi_m_bready,
      input  din_tdata, din_tkeep, din_tlast, din_tvalid,
      output din_tready
   );

   modport slave (
      output cmd_address, cmd_bytes, cmd_valid,
      input  cmd_ready,
      input  sts_bytes, sts_error, sts_early, sts_valid,
      output sts_ready,
      input  axi_m_awid, axi_m_awaddr, axi_m_awlen, axi_m_awsize, axi_m_awburst, axi_m_awvalid,
      output axi_m_awready,
      input  axi_m_wid, axi_m_wdata, axi_m_wstrb, axi_m_wlast, axi_m_wvalid,
      output axi_m_wready,
      output axi_m_bid, axi_m_bresp, axi_m_bvalid,
      input  axi_m_bready,
      output din_tdata, din_tkeep, din_tlast, din_tvalid,
      input  din_tready
   );
endinterface

// File: rtl/axi_wdma_ng.sv
// Stream-to-AXI write DMA: splits a command into INCR bursts (MAX_BURST / 4 KB limited),
// one burst outstanding, pads the burst after an early tlast and reports bytes/error/early.
module axi_wdma_ng #(
   parameter int         ADDRESS_BITS = 32,
   parameter int         LENGTH_BITS  = 32,
   parameter int         DATA_WIDTH   = 32,
   parameter int         MAX_BURST    = 256,
   parameter logic [3:0] AXI_ID       = 4'd0
) (
   input logic           aclk,
   input logic           areset,
   axi_wdma_ng_if.master bus
);
   localparam int BPB = DATA_WIDTH / 8;
   localparam int SZ  = $clog2(BPB);

   typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, RESP, STAT} state_t;

   state_t                  state_q, state_d;
   logic [ADDRESS_BITS-1:0] addr_q, addr_d;
   logic [LENGTH_BITS-1:0]  remaining_q, remaining_d;
   logic [8:0]              burst_q, burst_d;
   logic [7:0]              awlen_q, awlen_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    pad_q, pad_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    awvalid_q, awvalid_d;
   logic                    bready_q, bready_d;
   logic                    sts_valid_q, sts_valid_d;
   logic                    sts_error_q, sts_error_d;
   logic                    sts_early_q, sts_early_d;
   logic [LENGTH_BITS-1:0]  sts_bytes_q, sts_bytes_d;

   logic                    in_data, wlast, w_fire, s_fire;
   logic [LENGTH_BITS-1:0]  cmd_beats, burst_calc;
   logic [12:0]             to_4k;
   logic                    unused_bits;

   function automatic logic [LENGTH_BITS-1:0] popcount(input logic [BPB-1:0] k);
      popcount = '0;
      for (int i = 0; i < BPB; i++) popcount = popcount + LENGTH_BITS'(k[i]);
   endfunction

   assign cmd_beats = (bus.cmd_bytes >> SZ) + LENGTH_BITS'(|bus.cmd_bytes[SZ-1:0]);
   assign to_4k     = (13'd4096 - {1'b0, addr_q[11:0]}) >> SZ;

   always_comb begin
      burst_calc = remaining_q;
      if (burst_calc > LENGTH_BITS'(MAX_BURST)) burst_calc = LENGTH_BITS'(MAX_BURST);
      if (burst_calc > LENGTH_BITS'(to_4k))     burst_calc = LENGTH_BITS'(to_4k);
   end

   assign in_data = (state_q == DATA);
   assign wlast   = in_data && (cnt_q == awlen_q);

   assign bus.axi_m_awid    = AXI_ID;
   assign bus.axi_m_awaddr  = addr_q;
   assign bus.axi_m_awlen   = awlen_q;
   assign bus.axi_m_awsize  = 3'(SZ);
   assign bus.axi_m_awburst = 2'b01;
   assign bus.axi_m_awvalid = awvalid_q;
   assign bus.axi_m_wid     = AXI_ID;
   // Once padding, the stream is frozen and zero-strobe filler beats close the burst.
   assign bus.axi_m_wvalid  = in_data && (pad_q || bus.din_tvalid);
   assign bus.axi_m_wdata   = pad_q ? '0 : bus.din_tdata;
   assign bus.axi_m_wstrb   = pad_q ? '0 : bus.din_tkeep;
   assign bus.axi_m_wlast   = wlast;
   assign bus.axi_m_bready  = bready_q;
   assign bus.din_tready    = in_data && !pad_q && bus.axi_m_wready;
   assign bus.cmd_ready     = cmd_ready_q;
   assign bus.sts_valid     = sts_valid_q;
   assign bus.sts_error     = sts_error_q;
   assign bus.sts_early     = sts_early_q;
   assign bus.sts_bytes     = sts_bytes_q;

   assign w_fire = bus.axi_m_wvalid && bus.axi_m_wready;
   assign s_fire = bus.din_tvalid && bus.din_tready;
   assign unused_bits = ^{bus.axi_m_bid, burst_calc[LENGTH_BITS-1:9]};

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      burst_d     = burst_q;
      awlen_d     = awlen_q;
      cnt_d       = cnt_q;
      pad_d       = pad_q;
      cmd_ready_d = cmd_ready_q;
      awvalid_d   = awvalid_q;
      bready_d    = bready_q;
      sts_valid_d = sts_valid_q;
      sts_error_d = sts_error_q;
      sts_early_d = sts_early_q;
      sts_bytes_d = sts_bytes_q;
      case (state_q)
         IDLE: if (bus.cmd_valid) begin
            addr_d      = bus.cmd_address & ~ADDRESS_BITS'(BPB - 1);
            remaining_d = cmd_beats;
            cmd_ready_d = 1'b0;
            sts_bytes_d = '0;
            sts_error_d = 1'b0;
            sts_early_d = 1'b0;
            if (cmd_beats == '0) begin
               state_d     = STAT;
               sts_valid_d = 1'b1;
            end else begin
               state_d = CALC;
            end
         end
         CALC: begin
            burst_d   = burst_calc[8:0];
            awlen_d   = 8'(burst_calc - 1'b1);
            cnt_d     = '0;
            pad_d     = 1'b0;
            awvalid_d = 1'b1;
            state_d   = ADDR;
         end
         ADDR: if (bus.axi_m_awready) begin
            awvalid_d = 1'b0;
            state_d   = DATA;
         end
         DATA: begin
            if (s_fire) sts_bytes_d = sts_bytes_q + popcount(bus.din_tkeep);
            if (w_fire) begin
               cnt_d       = cnt_q + 8'd1;
               remaining_d = remaining_q - 1'b1;
               // tlast on the command's final beat is the normal end, not an early one.
               if (s_fire && bus.din_tlast && remaining_q != LENGTH_BITS'(1)) begin
                  sts_early_d = 1'b1;
                  pad_d       = !wlast;
               end
               if (wlast) begin
                  pad_d    = 1'b0;
                  bready_d = 1'b1;
                  state_d  = RESP;
               end
            end
         end
         RESP: if (bus.axi_m_bvalid) begin
            bready_d    = 1'b0;
            sts_error_d = sts_error_q | (bus.axi_m_bresp != 2'b00);
            addr_d      = addr_q + (ADDRESS_BITS'(burst_q) << SZ);
            if (remaining_q != '0 && !sts_early_q) begin
               state_d = CALC;
            end else begin
               state_d     = STAT;
               sts_valid_d = 1'b1;
            end
         end
         STAT: if (bus.sts_ready) begin
            sts_valid_d = 1'b0;
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         burst_q     <= '0;
         awlen_q     <= '0;
         cnt_q       <= '0;
         pad_q       <= 1'b0;
         cmd_ready_q <= 1'b1;
         awvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         sts_valid_q <= 1'b0;
         sts_error_q <= 1'b0;
         sts_early_q <= 1'b0;
         sts_bytes_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         burst_q     <= burst_d;
         awlen_q     <= awlen_d;
         cnt_q       <= cnt_d;
         pad_q       <= pad_d;
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         bready_q    <= bready_d;
         sts_valid_q <= sts_valid_d;
         sts_error_q <= sts_error_d;
         sts_early_q <= sts_early_d;
         sts_bytes_q <= sts_bytes_d;
      end
   end
endmodule

// File: tb/tb_axi_wdma_ng.sv
// Directed bench for axi_wdma_ng: 32-bit instance for most scenarios, 64-bit/MAX_BURST=16
// instance for the 4 KB split case; AXI slave and stream source are simple queue models.
module tb_axi_wdma_ng;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int vec  = 0;
   int miss = 0;

   axi_wdma_ng_if #(.ADDRESS_BITS(32), .LENGTH_BITS(32), .DATA_WIDTH(32)) b32 ();
   axi_wdma_ng_if #(.ADDRESS_BITS(32), .LENGTH_BITS(32), .DATA_WIDTH(64)) b64 ();

   axi_wdma_ng dut32 (.aclk(clk), .areset(rst), .bus(b32.master));
   axi_wdma_ng #(.DATA_WIDTH(64), .MAX_BURST(16)) dut64 (.aclk(clk), .areset(rst), .bus(b64.master));

   logic [31:0] aw_addr[$];
   logic [7:0]  aw_len[$];
   logic [3:0]  w_strb[$];
   logic [31:0] w_data[$];
   int          w_last_cnt = 0;
   int          pend_b     = 0;
   int          b_cnt      = 0;
   int          err_idx    = -1;
   bit          aw_seen    = 0;
   bit          stall      = 0;
   logic [31:0] s_data[$];
   logic [3:0]  s_keep[$];
   bit          s_last[$];

   logic [31:0] aw64_addr[$];
   logic [7:0]  aw64_len[$];
   int          pend_b64 = 0;
   int          s64_left = 0;

   // Handshake monitor: sampled on the active edge, before state updates.
   initial forever begin
      @(posedge clk);
      if (!rst) begin
         if (b32.axi_m_awvalid) aw_seen = 1;
         if (b32.axi_m_awvalid && b32.axi_m_awready) begin
            aw_addr.push_back(b32.axi_m_awaddr);
            aw_len.push_back(b32.axi_m_awlen);
         end
         if (b32.axi_m_wvalid && b32.axi_m_wready) begin
            w_strb.push_back(b32.axi_m_wstrb);
            w_data.push_back(b32.axi_m_wdata);
            if (b32.axi_m_wlast) begin w_last_cnt++; pend_b++; end
         end
         if (b32.axi_m_bvalid && b32.axi_m_bready) begin pend_b--; b_cnt++; end
         if (b32.din_tvalid && b32.din_tready && s_data.size() > 0) begin
            void'(s_data.pop_front()); void'(s_keep.pop_front()); void'(s_last.pop_front());
         end
         if (b64.axi_m_awvalid && b64.axi_m_awready) begin
            aw64_addr.push_back(b64.axi_m_awaddr);
            aw64_len.push_back(b64.axi_m_awlen);
         end
         if (b64.axi_m_wvalid && b64.axi_m_wready && b64.axi_m_wlast) pend_b64++;
         if (b64.axi_m_bvalid && b64.axi_m_bready) pend_b64--;
         if (b64.din_tvalid && b64.din_tready) s64_left--;
      end
   end

   // Slave / source driver on the inactive edge.
   initial begin
      b32.axi_m_awready = 0; b32.axi_m_wready = 0; b32.axi_m_bvalid = 0;
      b32.axi_m_bresp = 0; b32.axi_m_bid = 0;
      b32.din_tvalid = 0; b32.din_tdata = 0; b32.din_tkeep = 0; b32.din_tlast = 0;
      b64.axi_m_awready = 0; b64.axi_m_wready = 0; b64.axi_m_bvalid = 0;
      b64.axi_m_bresp = 0; b64.axi_m_bid = 0;
      b64.din_tvalid = 0; b64.din_tdata = 0; b64.din_tkeep = 0; b64.din_tlast = 0;
      forever begin
         @(negedge clk);
         b32.axi_m_awready = !stall || ($urandom_range(0, 1) == 1);
         b32.axi_m_wready  = !stall || ($urandom_range(0, 1) == 1);
         b32.axi_m_bvalid  = (pend_b > 0) && (!stall || ($urandom_range(0, 1) == 1));
         b32.axi_m_bresp   = (b_cnt == err_idx) ? 2'b10 : 2'b00;
         b32.din_tvalid    = (s_data.size() > 0) && (!stall || ($urandom_range(0, 1) == 1));
         b32.din_tdata     = (s_data.size() > 0) ? s_data[0] : 32'h0;
         b32.din_tkeep     = (s_keep.size() > 0) ? s_keep[0] : 4'h0;
         b32.din_tlast     = (s_last.size() > 0) ? s_last[0] : 1'b0;
         b64.axi_m_awready = 1;
         b64.axi_m_wready  = 1;
         b64.axi_m_bvalid  = (pend_b64 > 0);
         b64.din_tvalid    = (s64_left > 0);
         b64.din_tdata     = {2{32'(s64_left)}};
         b64.din_tkeep     = 8'hFF;
         b64.din_tlast     = (s64_left == 1);
      end
   end

   task automatic clear_sb();
      aw_addr.delete(); aw_len.delete(); w_strb.delete(); w_data.delete();
      w_last_cnt = 0; b_cnt = 0; aw_seen = 0;
   endtask

   task automatic push_beat(input logic [31:0] d, input logic [3:0] k, input bit l);
      s_data.push_back(d); s_keep.push_back(k); s_last.push_back(l);
   endtask

   task automatic send_cmd(input logic [31:0] a, input logic [31:0] n);
      @(negedge clk);
      b32.cmd_address = a; b32.cmd_bytes = n; b32.cmd_valid = 1;
      @(negedge clk);
      b32.cmd_valid = 0;
   endtask

   task automatic wait_sts(output bit ok);
      ok = 0;
      for (int i = 0; i < 5000; i++) begin
         @(posedge clk); #1;
         if (b32.sts_valid) begin ok = 1; break; end
      end
   endtask

   task automatic ack_sts();
      @(negedge clk); b32.sts_ready = 1;
      @(negedge clk); b32.sts_ready = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      vec++;
      if ({b32.cmd_ready, b32.axi_m_awvalid, b32.axi_m_wvalid, b32.axi_m_bready, b32.sts_valid,
           b32.sts_error, b32.sts_early, b32.din_tready} !== 8'b1000_0000) begin
         miss++; $display("FAIL reset_ctrl got %b want 10000000", {b32.cmd_ready, b32.axi_m_awvalid,
            b32.axi_m_wvalid, b32.axi_m_bready, b32.sts_valid, b32.sts_error, b32.sts_early, b32.din_tready});
      end
      vec++;
      if (b32.sts_bytes !== 32'h0) begin miss++; $display("FAIL reset_bytes got %0h want 0", b32.sts_bytes); end
      vec++;
      if (b64.cmd_ready !== 1'b1) begin miss++; $display("FAIL reset_cmd_ready64 got %b want 1", b64.cmd_ready); end
      @(negedge clk); rst = 0;
   endtask

   task automatic test_basic();
      bit ok;
      clear_sb();
      for (int i = 0; i < 256; i++) push_beat(32'hA000_0000 + 32'(i), 4'hF, i == 255);
      send_cmd(32'h1000, 32'd1024);
      wait_sts(ok);
      vec++; if (!ok) begin miss++; $display("FAIL basic_timeout got 0 want 1"); end
      vec++;
      if (aw_addr.size() != 1 || aw_addr[0] !== 32'h1000 || aw_len[0] !== 8'd255) begin
         miss++; $display("FAIL basic_aw got n=%0d addr=%0h len=%0d want n=1 addr=1000 len=255",
                          aw_addr.size(), aw_addr.size() ? aw_addr[0] : 0, aw_len.size() ? aw_len[0] : 0);
      end
      vec++;
      if (w_strb.size() != 256 || w_last_cnt != 1) begin
         miss++; $display("FAIL basic_wbeats got %0d/%0d want 256/1", w_strb.size(), w_last_cnt);
      end
      vec++;
      if (w_data.size() > 100 && w_data[100] !== 32'hA000_0064) begin
         miss++; $display("FAIL basic_wdata got %0h want a0000064", w_data[100]);
      end
      vec++;
      if (b32.sts_bytes !== 32'd1024 || b32.sts_error !== 1'b0 || b32.sts_early !== 1'b0) begin
         miss++; $display("FAIL basic_sts got bytes=%0d err=%b early=%b want 1024/0/0",
                          b32.sts_bytes, b32.sts_error, b32.sts_early);
      end
      vec++;
      if ({b32.axi_m_awsize, b32.axi_m_awburst, b32.axi_m_awid, b32.axi_m_wid} !== {3'd2, 2'b01, 4'd0, 4'd0}) begin
         miss++; $display("FAIL basic_consts got size=%0d burst=%0d id=%0d want 2/1/0",
                          b32.axi_m_awsize, b32.axi_m_awburst, b32.axi_m_awid);
      end
      ack_sts();
   endtask

   task automatic test_4k_split();
      bit ok;
      aw64_addr.delete(); aw64_len.delete();
      s64_left = 32;
      @(negedge clk);
      b64.cmd_address = 32'h0FC0; b64.cmd_bytes = 32'd256; b64.cmd_valid = 1;
      @(negedge clk);
      b64.cmd_valid = 0;
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (b64.sts_valid) begin ok = 1; break; end
      end
      vec++; if (!ok) begin miss++; $display("FAIL split_timeout got 0 want 1"); end
      vec++;
      if (aw64_addr.size() != 3) begin
         miss++; $display("FAIL split_count got %0d want 3", aw64_addr.size());
      end else begin
         if ({aw64_addr[0], aw64_addr[1], aw64_addr[2]} !== {32'h0FC0, 32'h1000, 32'h1080}) begin
            miss++; $display("FAIL split_addr got %0h %0h %0h want fc0 1000 1080",
                             aw64_addr[0], aw64_addr[1], aw64_addr[2]);
         end
         vec++;
         if ({aw64_len[0], aw64_len[1], aw64_len[2]} !== {8'd7, 8'd15, 8'd7}) begin
            miss++; $display("FAIL split_len got %0d %0d %0d want 7 15 7",
                             aw64_len[0], aw64_len[1], aw64_len[2]);
         end
      end
      vec++;
      if (b64.sts_bytes !== 32'd256) begin miss++; $display("FAIL split_bytes got %0d want 256", b64.sts_bytes); end
      @(negedge clk); b64.sts_ready = 1;
      @(negedge clk); b64.sts_ready = 0;
   endtask

   task automatic test_early();
      bit ok;
      int bad;
      clear_sb();
      for (int i = 0; i < 4; i++) push_beat(32'h5500_0000 + 32'(i), 4'hF, 0);
      push_beat(32'h5500_0004, 4'h3, 1);
      send_cmd(32'h4000, 32'd64);
      wait_sts(ok);
      vec++; if (!ok) begin miss++; $display("FAIL early_timeout got 0 want 1"); end
      vec++;
      if (aw_addr.size() != 1 || aw_len[0] !== 8'd15) begin
         miss++; $display("FAIL early_aw got n=%0d len=%0d want 1/15", aw_addr.size(), aw_len.size() ? aw_len[0] : 0);
      end
      bad = 0;
      for (int i = 5; i < 16 && i < w_strb.size(); i++) if (w_strb[i] !== 4'h0 || w_data[i] !== 32'h0) bad++;
      vec++;
      if (w_strb.size() != 16 || bad != 0 || w_strb[4] !== 4'h3 || w_last_cnt != 1) begin
         miss++; $display("FAIL early_pad got beats=%0d bad=%0d strb4=%0h want 16/0/3", w_strb.size(), bad,
                          w_strb.size() > 4 ? w_strb[4] : 4'h0);
      end
      vec++;
      if (b32.sts_bytes !== 32'd18 || b32.sts_early !== 1'b1 || s_data.size() != 0) begin
         miss++; $display("FAIL early_sts got bytes=%0d early=%b left=%0d want 18/1/0",
                          b32.sts_bytes, b32.sts_early, s_data.size());
      end
      ack_sts();
   endtask

   task automatic test_exact_len();
      bit ok;
      clear_sb();
      push_beat(32'h1, 4'hF, 0);
      push_beat(32'h2, 4'hF, 1);
      push_beat(32'h3, 4'hF, 1);
      send_cmd(32'h5000, 32'd8);
      wait_sts(ok);
      vec++; if (!ok) begin miss++; $display("FAIL exact_timeout got 0 want 1"); end
      vec++;
      if (b32.sts_early !== 1'b0 || b32.sts_bytes !== 32'd8 || w_strb.size() != 2 || s_data.size() != 1) begin
         miss++; $display("FAIL exact_sts got early=%b bytes=%0d beats=%0d left=%0d want 0/8/2/1",
                          b32.sts_early, b32.sts_bytes, w_strb.size(), s_data.size());
      end
      s_data.delete(); s_keep.delete(); s_last.delete();
      ack_sts();
   endtask

   task automatic test_slverr();
      bit ok;
      clear_sb();
      err_idx = 1;
      for (int i = 0; i < 304; i++) push_beat(32'(i), 4'hF, i == 303);
      send_cmd(32'h0F80, 32'd1216);
      wait_sts(ok);
      vec++; if (!ok) begin miss++; $display("FAIL slverr_timeout got 0 want 1"); end
      vec++;
      if (aw_addr.size() != 3) begin
         miss++; $display("FAIL slverr_count got %0d want 3", aw_addr.size());
      end else if ({aw_addr[0], aw_addr[1], aw_addr[2], aw_len[0], aw_len[1], aw_len[2]} !==
                   {32'h0F80, 32'h1000, 32'h1400, 8'd31, 8'd255, 8'd15}) begin
         miss++; $display("FAIL slverr_bursts got %0h/%0d %0h/%0d %0h/%0d want f80/31 1000/255 1400/15",
                          aw_addr[0], aw_len[0], aw_addr[1], aw_len[1], aw_addr[2], aw_len[2]);
      end
      vec++;
      if (b32.sts_error !== 1'b1 || b_cnt != 3 || b32.sts_bytes !== 32'd1216) begin
         miss++; $display("FAIL slverr_sts got err=%b b=%0d bytes=%0d want 1/3/1216",
                          b32.sts_error, b_cnt, b32.sts_bytes);
      end
      err_idx = -1;
      ack_sts();
   endtask

   task automatic test_zero();
      bit ok;
      clear_sb();
      send_cmd(32'h6000, 32'd0);
      wait_sts(ok);
      vec++; if (!ok) begin miss++; $display("FAIL zero_timeout got 0 want 1"); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         vec++;
         if ({b32.sts_valid, b32.cmd_ready, b32.sts_error, b32.sts_early} !== 4'b1000 || b32.sts_bytes !== 32'd0) begin
            miss++; $display("FAIL zero_hold cyc=%0d got vld/rdy/err/early=%b bytes=%0d want 1000/0", i,
                             {b32.sts_valid, b32.cmd_ready, b32.sts_error, b32.sts_early}, b32.sts_bytes);
         end
      end
      vec++;
      if (aw_seen !== 1'b0) begin miss++; $display("FAIL zero_noaw got %b want 0", aw_seen); end
      ack_sts();
   endtask

   task automatic test_reset_mid();
      bit ok;
      clear_sb();
      stall = 1;
      for (int i = 0; i < 100; i++) push_beat(32'hC000_0000 + 32'(i), 4'hF, i == 99);
      send_cmd(32'h2000, 32'd400);
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (w_strb.size() >= 10) begin ok = 1; break; end
      end
      vec++; if (!ok) begin miss++; $display("FAIL rstmid_timeout got 0 want 1"); end
      @(negedge clk); rst = 1;
      @(posedge clk); #1;
      vec++;
      if ({b32.cmd_ready, b32.axi_m_awvalid, b32.axi_m_wvalid, b32.axi_m_bready, b32.sts_valid,
           b32.sts_error, b32.sts_early, b32.din_tready} !== 8'b1000_0000 || b32.sts_bytes !== 32'h0) begin
         miss++; $display("FAIL rstmid_outputs got %b bytes=%0d want 10000000/0", {b32.cmd_ready, b32.axi_m_awvalid,
            b32.axi_m_wvalid, b32.axi_m_bready, b32.sts_valid, b32.sts_error, b32.sts_early, b32.din_tready},
            b32.sts_bytes);
      end
      s_data.delete(); s_keep.delete(); s_last.delete();
      pend_b = 0;
      clear_sb();
      @(negedge clk); rst = 0;
      for (int i = 0; i < 9; i++) push_beat(32'hD000_0000 + 32'(i), 4'hF, 0);
      push_beat(32'hD000_0009, 4'h3, 1);
      send_cmd(32'h3006, 32'd38);
      wait_sts(ok);
      vec++; if (!ok) begin miss++; $display("FAIL rstmid_next_timeout got 0 want 1"); end
      vec++;
      if (aw_addr.size() != 1 || aw_addr[0] !== 32'h3004 || aw_len[0] !== 8'd9) begin
         miss++; $display("FAIL rstmid_next_aw got n=%0d addr=%0h len=%0d want 1/3004/9", aw_addr.size(),
                          aw_addr.size() ? aw_addr[0] : 0, aw_len.size() ? aw_len[0] : 0);
      end
      vec++;
      if (b32.sts_bytes !== 32'd38 || b32.sts_early !== 1'b0 || w_strb.size() != 10) begin
         miss++; $display("FAIL rstmid_next_sts got bytes=%0d early=%b beats=%0d want 38/0/10",
                          b32.sts_bytes, b32.sts_early, w_strb.size());
      end
      stall = 0;
      ack_sts();
   endtask

   initial begin
      rst = 1;
      b32.cmd_address = 0; b32.cmd_bytes = 0; b32.cmd_valid = 0; b32.sts_ready = 0;
      b64.cmd_address = 0; b64.cmd_bytes = 0; b64.cmd_valid = 0; b64.sts_ready = 0;
      test_reset();
      test_basic();
      test_4k_split();
      test_early();
      test_exact_len();
      test_slverr();
      test_zero();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule

// File: doc/axi_wdma_ng.md
AXI_WDMA_NG -- requirements
Module: axi_wdma_ng

Interface
REQ-001 Parameters (name, default, meaning):
- ADDRESS_BITS, 32, AXI address width.
- LENGTH_BITS, 32, command byte-count width.
- DATA_WIDTH, 32, stream/AXI data width; legal values 32, 64, 128. BPB = DATA_WIDTH/8.
- MAX_BURST, 256, maximum beats per burst; power of two, 1..256.
- AXI_ID, 0, constant driven on awid/wid.

REQ-002 Ports (name, direction, width, meaning):
- aclk, in, 1, single clock.
- areset, in, 1, reset; synchronous, active-high.
- cmd_address, in, ADDRESS_BITS, start byte address.
- cmd_bytes, in, LENGTH_BITS, byte count.
- cmd_valid / cmd_ready, in / out, 1, command handshake.
- sts_bytes, out, LENGTH_BITS, bytes written.
- sts_error, out, 1, any non-OKAY bresp seen.
- sts_early, out, 1, s_tlast arrived before the command length was reached.
- sts_valid / sts_ready, out / in, 1, status handshake.
- axi_m_awid, awaddr, awlen, awsize, awburst, awvalid, awready: out 4 / ADDRESS_BITS / 8 / 3 / 2 / 1, in 1.
- axi_m_wid, wdata, wstrb, wlast, wvalid, wready: out 4 / DATA_WIDTH / BPB / 1 / 1, in 1.
- axi_m_bid, bresp, bvalid, bready: in 4 / 2 / 1, out 1.
- din_tdata, din_tkeep, din_tlast, din_tvalid, din_tready: in DATA_WIDTH / BPB / 1 / 1, out 1.

Function
REQ-003 The low log2(BPB) bits of cmd_address SHALL be forced to zero; beats = ceil(cmd_bytes/BPB).
REQ-004 Constants: awsize = log2(BPB); awburst = INCR; awid = wid = AXI_ID.
REQ-005 States: IDLE, CALC, ADDR, DATA, RESP, STAT.
REQ-006 IDLE: cmd_ready=1. On cmd_valid, latch the command and go to CALC; if beats==0, go directly to STAT instead.
REQ-007 CALC (1 cycle): burst = min(remaining beats, MAX_BURST, beats left to the next 4 KB boundary); awlen = burst-1; go to ADDR.
REQ-008 ADDR: awvalid=1, held with awaddr/awlen stable until awready; then go to DATA.
REQ-009 DATA: wvalid = din_tvalid and din_tready = wready; wdata = din_tdata, wstrb = din_tkeep, combinational.
REQ-010 A beat counter SHALL assert wlast when count==awlen; on wlast handshake go to RESP.
REQ-011 Early s_tlast: after din_tlast is accepted, the remaining beats of the current burst SHALL be padded with wvalid=1, wstrb=0, wdata=0, din_tready=0.
REQ-012 After an early s_tlast, sts_early SHALL be set and no further bursts SHALL be issued.
REQ-013 din_tlast on the final beat of the command is not early; beats beyond the command length SHALL NOT be consumed.
REQ-014 RESP: bready=1. On bvalid, OR (bresp!=0) into sts_error. Then: remaining>0 and not early goes to CALC, else to STAT.
REQ-015 Only one burst SHALL be outstanding; awaddr advances by burst*BPB after each burst.
REQ-016 sts_bytes SHALL accumulate the popcount of din_tkeep for every accepted stream beat.
REQ-017 STAT: sts_valid=1, status held stable until sts_ready; then go to IDLE.
REQ-018 Counters SHALL be LENGTH_BITS wide with no wrap; awaddr carry beyond ADDRESS_BITS is discarded.

Reset
REQ-019 areset SHALL be sampled on the aclk edge. Reset values: state=IDLE, cmd_ready=1, awvalid=0, wvalid=0, bready=0, sts_valid=0, sts_error=0, sts_early=0, sts_bytes=0, din_tready=0.
REQ-020 Reset mid-transfer SHALL abort immediately with no further AXI handshakes; an interrupted AXI transaction is not completed.

Verification
REQ-021 DATA_WIDTH=32: addr 0x1000, bytes 1024 -> bursts awaddr 0x1000/awlen 255; sts_bytes=1024, error=0.
REQ-022 DATA_WIDTH=64, MAX_BURST=16: addr 0x0FC0, bytes 256 -> bursts at 0x0FC0 (len 7), 0x1000 (len 15), 0x1080 (len 7).
REQ-023 bytes 64, din_tlast on beat 5 with tkeep=0x3 (DATA_WIDTH=32) -> beats 6..16 have wstrb=0, one burst only; sts_bytes=18, sts_early=1.
REQ-024 bresp=SLVERR on the 2nd of 3 bursts -> all 3 bursts complete; sts_error=1.
REQ-025 cmd_bytes=0 -> no awvalid; sts_valid with sts_bytes=0. Also: sts_ready held low 10 cycles -> status stable, cmd_ready=0.
REQ-026 Random wready/din_tvalid/awready/bvalid stalls with areset pulsed in DATA -> all outputs at reset values next cycle; a following command completes correctly.
